// File: rtl/dmem_responder.sv
// Data-memory responder: one access at a time, WAIT_STATES wait cycles, registered ready/err/read_data.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into err responses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] address,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state_q, state_d;

  logic [2:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic [2:0]    f3_q;
  logic [31:0]   wd_q;
  logic          rd_q, wr_q;
  logic          ready_q, err_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW+1:0] a;
  logic [2:0]    f3;
  logic [31:0]   wd;
  logic          rd, wr, accept, enter_resp;
  logic          bad, misal, fault, we;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wlane, word, shifted, ld;
  logic          unused_addr;

  assign unused_addr = ^address[31:AW+2];

  // With zero wait states the access enters RESP on its acceptance edge, so use the live inputs.
  always_comb begin
    if (state_q == IDLE) begin
      a = address[AW+1:0]; f3 = funct3; wd = write_data; rd = memread; wr = memwrite;
    end else begin
      a = addr_q; f3 = f3_q; wd = wd_q; rd = rd_q; wr = wr_q;
    end
  end

  assign accept = (state_q == IDLE) && (memread || memwrite);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        cnt_d   = 3'(WAIT_STATES);
        state_d = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_comb begin
    bad   = 1'b0;
    misal = 1'b0;
    if (rd && wr)  bad = 1'b1;
    else if (rd)   bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    else           bad = !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010));
`ifdef DMEM_MISALIGN_TRAP_EN
    misal = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
`else
    misal = 1'b0;
`endif
    fault = bad || misal;
  end

  // Low address bits are masked to the access size; misaligned cases are already faulted when trapping.
  always_comb begin
    case (f3[1:0])
      2'b00:   begin off = a[1:0];       be = 4'b0001 << off; wlane = {4{wd[7:0]}};  end
      2'b01:   begin off = {a[1], 1'b0}; be = 4'b0011 << off; wlane = {2{wd[15:0]}}; end
      default: begin off = 2'b00;        be = 4'b1111;        wlane = wd;            end
    endcase
  end

  assign word    = mem[a[AW+1:2]];
  assign shifted = word >> {off, 3'b000};

  always_comb begin
    case (f3)
      3'b000:  ld = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  ld = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld = {24'd0, shifted[7:0]};
      3'b101:  ld = {16'd0, shifted[15:0]};
      default: ld = shifted;
    endcase
  end

  assign we = enter_resp && wr && !fault && !reset;

  always_ff @(posedge clk) begin
    if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[a[AW+1:2]][8*b +: 8] <= wlane[8*b +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      wd_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= address[AW+1:0];
        f3_q   <= funct3;
        wd_q   <= write_data;
        rd_q   <= memread;
        wr_q   <= memwrite;
      end
      ready_q <= enter_resp;
      err_q   <= enter_resp && fault;
      rdata_q <= (enter_resp && rd && !fault) ? ld : 32'd0;
    end
  end

  assign ready     = ready_q;
  assign err       = err_q;
  assign read_data = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one instance with WAIT_STATES=1, one with WAIT_STATES=3, shared address/data/reset.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        memread, memwrite;
  logic [31:0] address, write_data;
  logic [2:0]  funct3;
  bit          sel_r;
  logic [31:0] rdata1, rdata3;
  logic        ready1, ready3, err1, err3;
  logic        mr1, mw1, mr3, mw3;

  int          total = 0, passed = 0;
  logic [31:0] d;
  logic        e;
  int          lat;
  bit          pulse;

  assign mr1 = memread  & ~sel_r;
  assign mw1 = memwrite & ~sel_r;
  assign mr3 = memread  &  sel_r;
  assign mw3 = memwrite &  sel_r;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .reset(rst), .memread(mr1), .memwrite(mw1), .address(address),
    .funct3(funct3), .write_data(write_data), .read_data(rdata1), .ready(ready1), .err(err1));

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(rst), .memread(mr3), .memwrite(mw3), .address(address),
    .funct3(funct3), .write_data(write_data), .read_data(rdata3), .ready(ready3), .err(err3));

  task automatic acc(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [2:0] f3, input logic [31:0] wd,
                     output logic [31:0] rdata, output logic er, output int l, output bit pl);
    @(negedge clk);
    sel_r = sel; address = a; funct3 = f3; write_data = wd; memread = rd; memwrite = wr;
    l = 0; rdata = '0; er = 1'b0; pl = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sel ? ready3 : ready1) begin
        l = i; rdata = sel ? rdata3 : rdata1; er = sel ? err3 : err1;
        break;
      end
    end
    memread = 1'b0; memwrite = 1'b0;
    @(posedge clk); #1;
    pl = !(sel ? ready3 : ready1);
  endtask

  task automatic test_reset;
    #1;
    total++; if (ready1 !== 1'b0) $display("FAIL rst_ready1 got %b want 0", ready1); else passed++;
    total++; if (err1 !== 1'b0) $display("FAIL rst_err1 got %b want 0", err1); else passed++;
    total++; if (rdata1 !== 32'd0) $display("FAIL rst_rdata1 got %h want 0", rdata1); else passed++;
    total++; if (ready3 !== 1'b0) $display("FAIL rst_ready3 got %b want 0", ready3); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_word;
    acc(0, 0, 1, 32'h10, 3'b010, 32'hDEADBEEF, d, e, lat, pulse);
    total++; if (lat !== 2) $display("FAIL sw_latency got %0d want 2", lat); else passed++;
    total++; if (e !== 1'b0) $display("FAIL sw_err got %b want 0", e); else passed++;
    acc(0, 1, 0, 32'h10, 3'b010, 32'h0, d, e, lat, pulse);
    total++; if (lat !== 2) $display("FAIL lw_latency got %0d want 2", lat); else passed++;
    total++; if (d !== 32'hDEADBEEF) $display("FAIL lw_data got %h want deadbeef", d); else passed++;
    total++; if (e !== 1'b0) $display("FAIL lw_err got %b want 0", e); else passed++;
    total++; if (pulse !== 1'b1) $display("FAIL ready_pulse got %b want 1", pulse); else passed++;
  endtask

  task automatic test_async_reset;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    sel_r = 0; address = 32'h10; funct3 = 3'b010; memread = 1'b1; memwrite = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = ready1;
    end
    total++; if (seen !== 1'b1) $display("FAIL async_seen got %b want 1", seen); else passed++;
    rst = 1'b1; memread = 1'b0;
    #1;
    total++; if (ready1 !== 1'b0) $display("FAIL async_ready got %b want 0", ready1); else passed++;
    total++; if (rdata1 !== 32'd0) $display("FAIL async_rdata got %h want 0", rdata1); else passed++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_byte;
    acc(0, 0, 1, 32'h10, 3'b010, 32'h0, d, e, lat, pulse);
    acc(0, 0, 1, 32'h13, 3'b000, 32'h80, d, e, lat, pulse);
    acc(0, 1, 0, 32'h13, 3'b000, 32'h0, d, e, lat, pulse);
    total++; if (d !== 32'hFFFFFF80) $display("FAIL lb got %h want ffffff80", d); else passed++;
    acc(0, 1, 0, 32'h13, 3'b100, 32'h0, d, e, lat, pulse);
    total++; if (d !== 32'h00000080) $display("FAIL lbu got %h want 00000080", d); else passed++;
    acc(0, 1, 0, 32'h10, 3'b010, 32'h0, d, e, lat, pulse);
    total++; if (d !== 32'h80000000) $display("FAIL sb_word got %h want 80000000", d); else passed++;
  endtask

  task automatic test_half;
    logic [31:0] wa;
    acc(0, 0, 1, 32'h20, 3'b010, 32'h0, d, e, lat, pulse);
    acc(0, 0, 1, 32'h22, 3'b001, 32'h1234, d, e, lat, pulse);
    acc(0, 1, 0, 32'h22, 3'b101, 32'h0, d, e, lat, pulse);
    total++; if (d !== 32'h00001234) $display("FAIL lhu got %h want 00001234", d); else passed++;
    acc(0, 0, 1, 32'h20, 3'b001, 32'hABCD8001, d, e, lat, pulse);
    acc(0, 1, 0, 32'h20, 3'b001, 32'h0, d, e, lat, pulse);
    total++; if (d !== 32'hFFFF8001) $display("FAIL lh got %h want ffff8001", d); else passed++;
`ifdef DMEM_MISALIGN_TRAP_EN
    wa = 32'h420;
`else
    wa = 32'h422;
`endif
    acc(0, 1, 0, wa, 3'b010, 32'h0, d, e, lat, pulse);
    total++; if (d !== 32'h12348001) $display("FAIL wrap got %h want 12348001", d); else passed++;
  endtask

  task automatic test_misalign;
    logic [31:0] exp_lw, exp_lh, exp_w;
    logic        exp_e;
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_e = 1'b1; exp_lw = 32'h0; exp_lh = 32'h0; exp_w = 32'hCAFEF00D;
`else
    exp_e = 1'b0; exp_lw = 32'hCAFEF00D; exp_lh = 32'hFFFFF00D; exp_w = 32'h99999999;
`endif
    acc(0, 0, 1, 32'h10, 3'b010, 32'hCAFEF00D, d, e, lat, pulse);
    acc(0, 1, 0, 32'h11, 3'b010, 32'h0, d, e, lat, pulse);
    total++; if (e !== exp_e) $display("FAIL mis_lw_err got %b want %b", e, exp_e); else passed++;
    total++; if (d !== exp_lw) $display("FAIL mis_lw_data got %h want %h", d, exp_lw); else passed++;
    acc(0, 1, 0, 32'h11, 3'b001, 32'h0, d, e, lat, pulse);
    total++; if (d !== exp_lh) $display("FAIL mis_lh_data got %h want %h", d, exp_lh); else passed++;
    acc(0, 0, 1, 32'h13, 3'b010, 32'h99999999, d, e, lat, pulse);
    total++; if (e !== exp_e) $display("FAIL mis_sw_err got %b want %b", e, exp_e); else passed++;
    acc(0, 1, 0, 32'h10, 3'b010, 32'h0, d, e, lat, pulse);
    total++; if (d !== exp_w) $display("FAIL mis_sw_mem got %h want %h", d, exp_w); else passed++;
  endtask

  task automatic test_errors;
    acc(0, 0, 1, 32'h30, 3'b010, 32'hA5A5A5A5, d, e, lat, pulse);
    acc(0, 1, 1, 32'h30, 3'b010, 32'h0, d, e, lat, pulse);
    total++; if (e !== 1'b1) $display("FAIL rdwr_err got %b want 1", e); else passed++;
    total++; if (d !== 32'h0) $display("FAIL rdwr_data got %h want 0", d); else passed++;
    acc(0, 1, 0, 32'h30, 3'b011, 32'h0, d, e, lat, pulse);
    total++; if (e !== 1'b1) $display("FAIL ld011_err got %b want 1", e); else passed++;
    total++; if (d !== 32'h0) $display("FAIL ld011_data got %h want 0", d); else passed++;
    acc(0, 0, 1, 32'h30, 3'b100, 32'h0, d, e, lat, pulse);
    total++; if (e !== 1'b1) $display("FAIL st100_err got %b want 1", e); else passed++;
    acc(0, 1, 0, 32'h30, 3'b010, 32'h0, d, e, lat, pulse);
    total++; if (d !== 32'hA5A5A5A5) $display("FAIL err_mem got %h want a5a5a5a5", d); else passed++;
    total++; if (e !== 1'b0) $display("FAIL err_clear got %b want 0", e); else passed++;
  endtask

  task automatic test_reset_mid;
    bit stray;
    stray = 1'b0;
    acc(1, 0, 1, 32'h40, 3'b010, 32'h11223344, d, e, lat, pulse);
    total++; if (lat !== 4) $display("FAIL ws3_latency got %0d want 4", lat); else passed++;
    @(negedge clk);
    sel_r = 1; address = 32'h40; funct3 = 3'b010; write_data = 32'h55; memread = 1'b0; memwrite = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; memwrite = 1'b0;
    #1;
    total++; if ({ready3, err3, rdata3} !== 34'd0) $display("FAIL mid_rst_outs got %b/%b/%h want 0", ready3, err3, rdata3); else passed++;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ready3) stray = 1'b1;
    end
    total++; if (stray !== 1'b0) $display("FAIL mid_rst_ready got %b want 0", stray); else passed++;
    acc(1, 1, 0, 32'h40, 3'b010, 32'h0, d, e, lat, pulse);
    total++; if (d !== 32'h11223344) $display("FAIL mid_rst_mem got %h want 11223344", d); else passed++;
  endtask

  initial begin
    rst = 1'b1; memread = 1'b0; memwrite = 1'b0; address = '0; funct3 = '0; write_data = '0; sel_r = 0;
    test_reset();
    test_word();
    test_async_reset();
    test_byte();
    test_half();
    test_misalign();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
